cic_ctrl_sched: RTL

Sequencing controller for the time-multiplexed CIC decimator in the uDMA I2S/PDM path. Each input frame carries one sample per active channel (1–4 channels). For each frame the block sweeps the shared 4-slot integrator chain one channel per cycle. It counts frames to find decimation boundaries. At a boundary it steps the comb stage per channel under a valid/ready output handshake. Frames arriving while a sweep is in progress are dropped and flagged.

---
 rtl/cic_ctrl_sched_if.sv | 32 +++
 rtl/cic_ctrl_sched.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/cic_ctrl_sched_if.sv
// Handshake and control bundle between cic_ctrl_sched and the CIC datapath.
// slave = controller side, master = datapath/environment side.
interface cic_ctrl_sched_if;
    logic       sample_valid_i;
    logic       sample_ready_o;
    logic       sample_drop_o;
    logic       integ_en_o;
    logic       integ_clr_o;
    logic [1:0] integ_sel_o;
    logic       comb_en_o;
    logic       comb_clr_o;
    logic [1:0] comb_sel_o;
    logic       out_valid_o;
    logic [1:0] out_ch_o;
    logic       out_ready_i;

    modport slave (
        input  sample_valid_i, out_ready_i,
        output sample_ready_o, sample_drop_o,
               integ_en_o, integ_clr_o, integ_sel_o,
               comb_en_o, comb_clr_o, comb_sel_o,
               out_valid_o, out_ch_o
    );

    modport master (
        output sample_valid_i, out_ready_i,
        input  sample_ready_o, sample_drop_o,
               integ_en_o, integ_clr_o, integ_sel_o,
               comb_en_o, comb_clr_o, comb_sel_o,
               out_valid_o, out_ch_o
    );
endinterface

// File: rtl/cic_ctrl_sched.sv
// Sequencer for the time-multiplexed CIC decimator: integrator sweep, decimation count, comb handshake.
// Optional dropped-frame counter enabled by defining CIC_CTRL_DROP_CNT_EN.
module cic_ctrl_sched #(
    parameter int unsigned DECIM_W = 10
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               cfg_en_i,
    input  logic [1:0]         cfg_nch_i,
    input  logic [DECIM_W-1:0] cfg_decim_i,
    input  logic               clr_i,
    cic_ctrl_sched_if.slave    bus,
    output logic [7:0]         drop_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INTEG = 2'd1,
        COMB  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         ch_q, ch_d;
    logic [1:0]         nch_q, nch_d;
    logic [DECIM_W-1:0] fcnt_q, fcnt_d;
    logic               en_q;

    logic       clear;
    logic       idle;
    logic       ready;
    logic       accept;
    logic       drop;
    logic       integ_en;
    logic [1:0] integ_sel;
    logic       out_valid;
    logic [1:0] out_ch;
    logic       comb_en;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            ch_q    <= '0;
            nch_q   <= '0;
            fcnt_q  <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            nch_q   <= nch_d;
            fcnt_q  <= fcnt_d;
            en_q    <= cfg_en_i;
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        nch_d     = nch_q;
        fcnt_d    = fcnt_q;
        integ_en  = 1'b0;
        integ_sel = '0;
        out_valid = 1'b0;
        out_ch    = '0;
        comb_en   = 1'b0;

        clear  = clr_i | (cfg_en_i ^ en_q);
        idle   = (state_q == IDLE);
        ready  = idle & cfg_en_i & ~clear;
        accept = ready & bus.sample_valid_i;
        drop   = ~idle & bus.sample_valid_i & cfg_en_i & ~clear;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    nch_d   = cfg_nch_i;
                    ch_d    = '0;
                    state_d = INTEG;
                end
            end
            INTEG: begin
                integ_en  = 1'b1;
                integ_sel = ch_q;
                if (ch_q == nch_q) begin
                    ch_d = '0;
                    if (fcnt_q == cfg_decim_i) begin
                        fcnt_d  = '0;
                        state_d = COMB;
                    end else begin
                        fcnt_d  = fcnt_q + {{(DECIM_W-1){1'b0}}, 1'b1};
                        state_d = IDLE;
                    end
                end else begin
                    ch_d = ch_q + 2'd1;
                end
            end
            COMB: begin
                out_valid = 1'b1;
                out_ch    = ch_q;
                comb_en   = bus.out_ready_i;
                if (bus.out_ready_i) begin
                    if (ch_q == nch_q) begin
                        ch_d    = '0;
                        state_d = IDLE;
                    end else begin
                        ch_d = ch_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear overrides every decode above, including a frame presented this cycle.
        if (clear) begin
            state_d   = IDLE;
            ch_d      = '0;
            fcnt_d    = '0;
            integ_en  = 1'b0;
            integ_sel = '0;
            out_valid = 1'b0;
            out_ch    = '0;
            comb_en   = 1'b0;
        end
    end

    assign bus.sample_ready_o = ready;
    assign bus.sample_drop_o  = drop;
    assign bus.integ_en_o     = integ_en;
    assign bus.integ_sel_o    = integ_sel;
    assign bus.out_valid_o    = out_valid;
    assign bus.out_ch_o       = out_ch;
    assign bus.comb_sel_o     = out_ch;
    assign bus.comb_en_o      = comb_en;
    // en_q is held low in reset, so the edge detector must not leak a clear pulse while reset is asserted.
    assign bus.integ_clr_o    = clear & rstn_i;
    assign bus.comb_clr_o     = clear & rstn_i;

`ifdef CIC_CTRL_DROP_CNT_EN
    logic [7:0] dcnt_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            dcnt_q <= '0;
        end else if (clear) begin
            dcnt_q <= '0;
        end else if (drop && (dcnt_q != 8'hFF)) begin
            dcnt_q <= dcnt_q + 8'd1;
        end
    end

    assign drop_cnt_o = dcnt_q;
`else
    assign drop_cnt_o = '0;
`endif

endmodule
